// File: rtl/tof_roi_sequencer.sv
// ROI readout sequencer: free-running ROI pixel clock, frame window and row/column
// addressing for the sensor, with frame/overrun/count status for the control CPU.
module tof_roi_sequencer #(
  parameter  int unsigned CLK_DIV   = 12,
  parameter  int unsigned ROI_COLS  = 55,
  parameter  int unsigned ROI_ROWS  = 120,
  parameter  int unsigned FRAME_GAP = 4,
  localparam int unsigned ADDR_W    = 7,
  localparam int unsigned CNT_W     = 16
) (
  input  logic              clk_adc_i,
  input  logic              rst_n_i,
  input  logic              frame_start_i,
  input  logic              cont_i,
  input  logic              abort_i,
  output logic              sns_clk_roi_o,
  output logic              sns_enable_roi_o,
  output logic [ADDR_W-1:0] sns_col_o,
  output logic [ADDR_W-1:0] sns_row_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  frame_cnt_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned GAP_W = $clog2(FRAME_GAP + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_left_q, gap_d;
  logic               pending_q;
  logic               abort_hold_q, hold_d;
  logic [ADDR_W-1:0]  col_d, row_d;
  logic               en_d, done_d, starting;
  logic [CNT_W-1:0]   cnt_d;
  logic               bnd, go, first_period, last_col, last_row;

  assign bnd          = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign go           = pending_q | frame_start_i | cont_i;
  assign first_period = (sns_col_o == '0) && (sns_row_o == '0);
  assign last_col     = (sns_col_o == ADDR_W'(ROI_COLS - 1));
  assign last_row     = (sns_row_o == ADDR_W'(ROI_ROWS - 1));

  // Free-running divider; the ROI clock rises on the wrap so every boundary lines up with it
  always_ff @(posedge clk_adc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt       <= '0;
      sns_clk_roi_o <= 1'b0;
    end else if (bnd) begin
      div_cnt       <= '0;
      sns_clk_roi_o <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      if (div_cnt == DIV_W'(CLK_DIV / 2 - 1)) begin
        sns_clk_roi_o <= 1'b0;
      end
    end
  end

  // State register and registered frame outputs
  always_ff @(posedge clk_adc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= S_IDLE;
      gap_left_q       <= '0;
      abort_hold_q     <= 1'b0;
      sns_enable_roi_o <= 1'b0;
      sns_col_o        <= '0;
      sns_row_o        <= '0;
      busy_o           <= 1'b0;
      frame_done_o     <= 1'b0;
      frame_cnt_o      <= '0;
    end else begin
      state_q          <= state_d;
      gap_left_q       <= gap_d;
      abort_hold_q     <= hold_d;
      sns_enable_roi_o <= en_d;
      sns_col_o        <= col_d;
      sns_row_o        <= row_d;
      busy_o           <= (state_d != S_IDLE);
      frame_done_o     <= done_d;
      frame_cnt_o      <= cnt_d;
    end
  end

  // Next-state logic. A mid-period abort needs one extra boundary so the enable-low
  // time still spans FRAME_GAP full periods; an abort in the first period is held to
  // its boundary so the window is never shorter than one period.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_left_q;
    hold_d   = abort_hold_q;
    col_d    = sns_col_o;
    row_d    = sns_row_o;
    en_d     = sns_enable_roi_o;
    done_d   = 1'b0;
    cnt_d    = frame_cnt_o;
    starting = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bnd && go) begin
          state_d  = S_ACTIVE;
          en_d     = 1'b1;
          col_d    = '0;
          row_d    = '0;
          starting = 1'b1;
        end
      end
      S_ACTIVE: begin
        if ((abort_i || abort_hold_q) && (bnd || !first_period)) begin
          state_d = S_GAP;
          en_d    = 1'b0;
          col_d   = '0;
          row_d   = '0;
          hold_d  = 1'b0;
          gap_d   = bnd ? GAP_W'(FRAME_GAP) : GAP_W'(FRAME_GAP + 1);
        end else if (abort_i) begin
          hold_d = 1'b1;
        end else if (bnd) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = S_GAP;
              en_d    = 1'b0;
              row_d   = '0;
              done_d  = 1'b1;
              cnt_d   = frame_cnt_o + CNT_W'(1);
              gap_d   = GAP_W'(FRAME_GAP);
            end else begin
              row_d = sns_row_o + ADDR_W'(1);
            end
          end else begin
            col_d = sns_col_o + ADDR_W'(1);
          end
        end
      end
      S_GAP: begin
        if (bnd) begin
          if (gap_left_q == GAP_W'(1)) begin
            if (go) begin
              state_d  = S_ACTIVE;
              en_d     = 1'b1;
              starting = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            gap_d = gap_left_q - GAP_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One outstanding request is remembered; a second one while it waits is an overrun
  always_ff @(posedge clk_adc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      pending_q <= starting ? 1'b0 : (pending_q | frame_start_i);
      if (frame_start_i && pending_q) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tof_roi_sequencer.sv
// Bench for tof_roi_sequencer: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed timings.
module tb_tof_roi_sequencer;

  localparam int DIV  = 12;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int GAP  = 2;
  localparam int FLEN = COLS * ROWS * DIV;

  logic        clk_adc_i     = 1'b0;
  logic        rst_n_i       = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        cont_i        = 1'b0;
  logic        abort_i       = 1'b0;
  logic        sns_clk_roi_o;
  logic        sns_enable_roi_o;
  logic [6:0]  sns_col_o;
  logic [6:0]  sns_row_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        overrun_o;
  logic [15:0] frame_cnt_o;

  tof_roi_sequencer #(
    .CLK_DIV  (DIV),
    .ROI_COLS (COLS),
    .ROI_ROWS (ROWS),
    .FRAME_GAP(GAP)
  ) dut (
    .clk_adc_i       (clk_adc_i),
    .rst_n_i         (rst_n_i),
    .frame_start_i   (frame_start_i),
    .cont_i          (cont_i),
    .abort_i         (abort_i),
    .sns_clk_roi_o   (sns_clk_roi_o),
    .sns_enable_roi_o(sns_enable_roi_o),
    .sns_col_o       (sns_col_o),
    .sns_row_o       (sns_row_o),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .overrun_o       (overrun_o),
    .frame_cnt_o     (frame_cnt_o)
  );

  always #5 clk_adc_i = ~clk_adc_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Reference model: frames are described by edge timestamps since reset release
  int m_t = 0, m_fs = 0, m_gend = 0, m_abort_at = 0, m_cnt = 0;
  bit m_active = 0, m_pend = 0, m_ovr = 0, m_done = 0;

  task automatic model_step();
    int e;
    int ab;
    bit go;
    bit starting;
    e        = m_t + 1;
    go       = m_pend | frame_start_i | cont_i;
    starting = 0;
    m_done   = 0;
    if (m_active) begin
      ab = m_abort_at;
      if (abort_i && ab == 0) ab = (e < m_fs + DIV) ? m_fs + DIV : e;
      if (ab == e) begin
        m_active   = 0;
        m_abort_at = 0;
        m_gend     = ((e + DIV - 1) / DIV) * DIV + GAP * DIV;
      end else begin
        m_abort_at = ab;
        if (e == m_fs + FLEN) begin
          m_active = 0;
          m_done   = 1;
          m_cnt    = (m_cnt + 1) % 65536;
          m_gend   = e + GAP * DIV;
        end
      end
    end else if (m_gend != 0) begin
      if (e == m_gend) begin
        m_gend = 0;
        if (go) starting = 1;
      end
    end else if (e % DIV == 0 && go) begin
      starting = 1;
    end
    if (starting) begin
      m_active = 1;
      m_fs     = e;
    end
    m_ovr = m_ovr | (frame_start_i & m_pend);
    m_pend = starting ? 1'b0 : (m_pend | frame_start_i);
    m_t = e;
  endtask

  initial begin
    forever begin
      @(posedge clk_adc_i or negedge rst_n_i);
      if (!rst_n_i) begin
        m_t = 0; m_fs = 0; m_gend = 0; m_abort_at = 0; m_cnt = 0;
        m_active = 0; m_pend = 0; m_ovr = 0; m_done = 0;
      end else begin
        model_step();
      end
    end
  end

  // Enable/done monitor for directed timing checks
  bit en_prev = 0;
  int high_run = 0, low_run = 0, last_high = 0, last_low = 0;
  int en_rises = 0, done_cnt = 0, done_misaligned = 0;

  initial begin
    forever begin
      @(negedge clk_adc_i);
      chk("clk_roi", sns_clk_roi_o, (m_t >= DIV && (m_t % DIV) < DIV / 2) ? 1 : 0);
      chk("enable", sns_enable_roi_o, m_active ? 1 : 0);
      chk("col", sns_col_o, m_active ? ((m_t - m_fs) / DIV) % COLS : 0);
      chk("row", sns_row_o, m_active ? ((m_t - m_fs) / DIV) / COLS : 0);
      chk("busy", busy_o, (m_active || m_gend != 0) ? 1 : 0);
      chk("frame_done", frame_done_o, m_done ? 1 : 0);
      chk("overrun", overrun_o, m_ovr ? 1 : 0);
      chk("frame_cnt", frame_cnt_o, m_cnt);
      if (sns_enable_roi_o) begin
        if (!en_prev) begin
          en_rises++;
          last_low = low_run;
          high_run = 0;
        end
        high_run++;
      end else begin
        if (en_prev) begin
          last_high = high_run;
          low_run = 0;
        end
        low_run++;
      end
      if (frame_done_o) begin
        done_cnt++;
        if (!(en_prev && !sns_enable_roi_o)) done_misaligned++;
      end
      en_prev = sns_enable_roi_o;
    end
  end

  task automatic tick();
    @(negedge clk_adc_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    ticks(3);
    rst_n_i = 1'b1;
  endtask

  task automatic wait_en(input bit v, input int max, input string name);
    int n;
    n = 0;
    while (sns_enable_roi_o !== v && n < max) begin
      tick();
      n++;
    end
    if (sns_enable_roi_o !== v) timeout(name);
  endtask

  task automatic wait_colrow(input int c, input int r, input int max, input string name);
    int n;
    n = 0;
    while (!(sns_col_o == 7'(c) && sns_row_o == 7'(r)) && n < max) begin
      tick();
      n++;
    end
    if (!(sns_col_o == 7'(c) && sns_row_o == 7'(r))) timeout(name);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    if (busy_o !== 1'b0) timeout(name);
  endtask

  task automatic wait_cnt(input int v, input int max, input string name);
    int n;
    n = 0;
    while (frame_cnt_o != 16'(v) && n < max) begin
      tick();
      n++;
    end
    if (frame_cnt_o != 16'(v)) timeout(name);
  endtask

  // Called right after reset release: first rise at 12, fall at 18, next rise at 24
  task automatic measure_clk(input int n, input string tag);
    int first_rise, first_fall, second_rise;
    bit prev;
    first_rise = 0; first_fall = 0; second_rise = 0; prev = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (sns_clk_roi_o && !prev) begin
        if (first_rise == 0) first_rise = k;
        else if (second_rise == 0) second_rise = k;
      end
      if (!sns_clk_roi_o && prev && first_fall == 0) first_fall = k;
      prev = sns_clk_roi_o;
    end
    chk({tag, "_first_rise"}, first_rise, 12);
    chk({tag, "_first_fall"}, first_fall, 18);
    chk({tag, "_second_rise"}, second_rise, 24);
  endtask

  int r0, d0;

  initial begin
    // 1: clock start-up, idle outputs
    ticks(3);
    rst_n_i = 1'b1;
    measure_clk(100, "s1");
    chk("s1_en_rises", en_rises, 0);
    chk("s1_busy", busy_o, 0);

    // 2: single frame
    r0 = en_rises; d0 = done_cnt;
    pulse_start();
    wait_en(1'b1, 30, "s2_en_rise");
    wait_idle(400, "s2_idle");
    chk("s2_high_len", last_high, 144);
    chk("s2_done_pulses", done_cnt - d0, 1);
    chk("s2_done_aligned", done_misaligned, 0);
    chk("s2_frame_cnt", frame_cnt_o, 1);

    // 3: continuous frames, then drop cont mid frame 6
    do_reset();
    r0 = en_rises;
    cont_i = 1'b1;
    wait_cnt(5, 1200, "s3_cnt5");
    chk("s3_cnt5", frame_cnt_o, 5);
    chk("s3_low_len", last_low, 24);
    chk("s3_high_len", last_high, 144);
    wait_en(1'b1, 40, "s3_frame6");
    ticks(50);
    cont_i = 1'b0;
    wait_idle(400, "s3_idle");
    chk("s3_cnt6", frame_cnt_o, 6);
    chk("s3_rises", en_rises - r0, 6);
    ticks(40);
    chk("s3_no_more", en_rises - r0, 6);

    // 4: one queued request, then an overrun
    r0 = en_rises;
    pulse_start();
    wait_en(1'b1, 30, "s4a_rise");
    ticks(5);
    pulse_start();
    wait_idle(600, "s4a_idle");
    chk("s4a_rises", en_rises - r0, 2);
    chk("s4a_gap", last_low, 24);
    chk("s4a_overrun", overrun_o, 0);
    chk("s4a_cnt", frame_cnt_o, 8);
    r0 = en_rises;
    pulse_start();
    wait_en(1'b1, 30, "s4b_rise");
    ticks(3);
    pulse_start();
    ticks(3);
    pulse_start();
    wait_idle(600, "s4b_idle");
    chk("s4b_rises", en_rises - r0, 2);
    chk("s4b_overrun", overrun_o, 1);
    chk("s4b_cnt", frame_cnt_o, 10);

    // 5: abort mid period at col 2 row 1 with a request pending
    do_reset();
    r0 = en_rises; d0 = done_cnt;
    pulse_start();
    wait_en(1'b1, 30, "s5a_rise");
    pulse_start();
    wait_colrow(2, 1, 200, "s5a_colrow");
    tick();
    pulse_abort();
    chk("s5a_en_off", sns_enable_roi_o, 0);
    chk("s5a_cnt", frame_cnt_o, 0);
    chk("s5a_no_done", done_cnt - d0, 0);
    wait_idle(400, "s5a_idle");
    chk("s5a_gap", last_low, 34);
    chk("s5a_rises", en_rises - r0, 2);
    chk("s5a_done", done_cnt - d0, 1);
    chk("s5a_cnt_end", frame_cnt_o, 1);

    // 5b: abort coincident with a boundary
    pulse_start();
    wait_en(1'b1, 30, "s5b_rise");
    pulse_start();
    wait_colrow(1, 0, 30, "s5b_colrow");
    ticks(11);
    pulse_abort();
    chk("s5b_en_off", sns_enable_roi_o, 0);
    chk("s5b_high", last_high, 24);
    wait_idle(400, "s5b_idle");
    chk("s5b_gap", last_low, 24);
    chk("s5b_cnt", frame_cnt_o, 2);

    // 5c: abort in the first period is held to that period's end
    d0 = done_cnt;
    pulse_start();
    wait_en(1'b1, 30, "s5c_rise");
    tick();
    pulse_abort();
    chk("s5c_en_still", sns_enable_roi_o, 1);
    wait_en(1'b0, 30, "s5c_fall");
    chk("s5c_high", last_high, 12);
    wait_idle(100, "s5c_idle");
    chk("s5c_cnt", frame_cnt_o, 2);
    chk("s5c_no_done", done_cnt - d0, 0);

    // 6: asynchronous reset mid frame
    pulse_start();
    wait_en(1'b1, 30, "s6_rise");
    ticks(30);
    rst_n_i = 1'b0;
    #1;
    chk("s6_en", sns_enable_roi_o, 0);
    chk("s6_busy", busy_o, 0);
    chk("s6_col", sns_col_o, 0);
    chk("s6_cnt", frame_cnt_o, 0);
    chk("s6_clk", sns_clk_roi_o, 0);
    ticks(3);
    rst_n_i = 1'b1;
    measure_clk(30, "s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
